dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Parametrised data-memory controller that succeeds the fixed 128-word asynchronous DMEM used with the single-cycle CPU. It decodes byte addresses against a configurable base and depth, and performs little-endian byte, halfword and word loads and stores with sign or zero extension. A req/ready/done handshake with a configurable read latency lets the CPU stall on slow reads. Out-of-range and misaligned accesses are reported instead of silently wrapping.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, 16..65536.
- BASE_ADDR, 32'h10010000: byte address of word 0; word-aligned.
- RD_LAT, 1: read latency in cycles, legal range 1..4.
- clk_in  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  access request, qualified by ready.
- we  input  1  1 = store, 0 = load.
- size  input  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- sign_ext  input  1  loads only: 1 = sign-extend (lb/lh), 0 = zero-extend (lbu/lhu).
- addr  input  32  byte address.
- wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- ready  output  1  controller can accept a request this cycle.
- done  output  1  one-cycle completion pulse, for both loads and stores.
- rdata  output  32  load result; valid only while done is high after a load.
- err  output  1  valid only with done; 1 = access rejected.

## Operation
- Accept: req & ready sampled high at a rising edge. All inputs are captured at that edge.
- Decode:
  - off = addr − BASE_ADDR (32-bit).
  - Out-of-range when addr < BASE_ADDR or off ≥ DEPTH_WORDS·4.
  - Word index = off[log2(DEPTH_WORDS)+1:2].
  - Byte lane = off[1:0]; half lane = off[1].
- FSM states:
  - IDLE: ready = 1. A store is written at the accept edge and the FSM stays in IDLE. A load moves the FSM to RD with cnt = 1.
  - RD: ready = 0. cnt increments each edge. At the edge where cnt == RD_LAT, the array word is extracted and extended into rdata, done is set, and the FSM returns to IDLE.
- Stores modify only the addressed lanes:
  - Byte: wdata[7:0] goes to lane off[1:0].
  - Half: wdata[15:0] goes to bytes {2·off[1]+1, 2·off[1]}.
  - Word: all four bytes are written.
- Loads extract the addressed byte or half and extend it to 32 bits per sign_ext. Word loads ignore sign_ext.
- Rejected access (err = 1):
  - No array write.
  - rdata = 0.
  - done and err timing is identical to a successful access of the same type.
- Back-to-back: stores can be accepted every cycle. A new request can be accepted in the same cycle done is high for a load.
- Memory contents are not reset; the array is uninitialised until written.

## Timing
- Reset asserted: FSM = IDLE, cnt = 0, done = 0, err = 0, rdata = 0, and ready = 0 while reset is high. ready = 1 in the first cycle after release.
- Store accepted at edge k:
  - Array updated at edge k.
  - done (and err) high for exactly the cycle following edge k.
  - ready stays high throughout.
- Load accepted at edge k:
  - ready = 0 for cycles following edges k .. k+RD_LAT−1.
  - done, rdata and err are valid in the cycle following edge k+RD_LAT.
  - Total load latency is RD_LAT+1 edges from acceptance to sampled result.
- done is always a single-cycle pulse and is never asserted without a prior accept.
- Reset mid-load aborts the access: no done pulse and no array change. The outstanding load is lost.
- req while ready = 0 is ignored, not queued; the requester must hold req.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: the following accesses are rejected with err = 1 (no write, rdata = 0):
  - half access with off[0] = 1;
  - word access with off[1:0] ≠ 0.
- DMEM_MISALIGN_TRAP_EN undefined: misaligned low address bits are forced to zero (half ignores off[0]; word ignores off[1:0]). The access proceeds with err = 0, matching legacy DMEM behaviour. Out-of-range checking is present in both builds.

## Test plan
- Reset then sw: write 0xDEADBEEF to 0x10010000, then lw the same address with RD_LAT=1 → done two edges after the load accept, rdata = 0xDEADBEEF, err = 0.
- Sub-word store: sb 0x80 to 0x10010003 over 0x11223344 → lw returns 0x80223344. lb of 0x10010003 returns 0xFFFFFF80; lbu returns 0x00000080.
- Half: sh 0x9ABC to 0x10010006, then lh → 0xFFFF9ABC; lhu → 0x00009ABC. Bytes 4–5 of that word are unchanged.
- Range: lw at 0x1000FFFC and at BASE_ADDR + DEPTH_WORDS·4 → err = 1, rdata = 0. sw to those addresses → err = 1 and no memory word changes (verified by reading all words back).
- Misalign: lw at 0x10010002 → with DMEM_MISALIGN_TRAP_EN, err = 1; without it, returns the word at 0x10010000 with err = 0.
- RD_LAT=3: load accepted, reset pulsed at the second RD cycle → no done pulse, ready = 1 after release. Back-to-back sw every cycle for 8 cycles → 8 done pulses.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller with byte/half/word access, configurable read latency and range/alignment errors.
// Optional build macro DMEM_MISALIGN_TRAP_EN rejects misaligned halves and words instead of forcing low address bits to zero.
module dmem_ctrl #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int          RD_LAT      = 1
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
  typedef enum logic {IDLE, RD} state_t;
  state_t state, state_nx;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] off, wd, sh, ld_val;
  logic [AW-1:0] idx, ld_idx;
  logic [1:0] lane, ld_lane, ld_size;
  logic [3:0] be;
  logic [2:0] cnt;
  logic bad, acc, fin, ld_sx, ld_bad;
  assign off = addr - BASE_ADDR;
  assign idx = off[AW+1:2];
`ifdef DMEM_MISALIGN_TRAP_EN
  assign lane = off[1:0];
  assign bad  = addr < BASE_ADDR || off >= SPAN || (size == 2'd1 && off[0]) || (size[1] && off[1:0] != 2'd0);
`else
  assign lane = size[1] ? 2'b00 : size[0] ? {off[1], 1'b0} : off[1:0];
  assign bad  = addr < BASE_ADDR || off >= SPAN;
`endif
  assign ready = state == IDLE && !reset;
  assign acc   = req && ready;
  assign fin   = state == RD && cnt == 3'(RD_LAT);
  assign be    = size[1] ? 4'hf : size[0] ? 4'b0011 << lane : 4'b0001 << lane;
  assign wd    = size[1] ? wdata : size[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
  assign sh    = mem[ld_idx] >> {ld_lane, 3'b000};
  assign ld_val = ld_bad ? 32'd0 :
                  ld_size[1] ? mem[ld_idx] :
                  ld_size[0] ? {{16{ld_sx & sh[15]}}, sh[15:0]} :
                               {{24{ld_sx & sh[7]}}, sh[7:0]};
  always_comb state_nx = state == IDLE ? (acc && !we ? RD : IDLE) : (fin ? IDLE : RD);
  always_ff @(posedge clk_in)
    if (acc && we && !bad)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  // load context is captured at accept; the array is read when the latency expires
  always_ff @(posedge clk_in)
    if (acc && !we) begin
      ld_idx  <= idx;
      ld_lane <= lane;
      ld_size <= size;
      ld_sx   <= sign_ext;
      ld_bad  <= bad;
    end
  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= acc && !we ? 3'd1 : state == RD && !fin ? cnt + 3'd1 : 3'd0;
      done  <= (acc && we) || fin;
      err   <= acc && we ? bad : fin && ld_bad;
      rdata <= fin ? ld_val : 32'd0;
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for dmem_ctrl with a RD_LAT=1 instance and a small RD_LAT=3 instance.
module tb_dmem_ctrl;
  localparam logic [31:0] BASE = 32'h10010000;
  localparam int DP0 = 1024, DP1 = 16;
  typedef struct {int inst; int due; logic [31:0] d; logic e; logic ld;} exp_t;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset [2], req [2], we [2], sign_ext [2], ready [2], done [2], err [2];
  logic [1:0] size [2];
  logic [31:0] addr [2], wdata [2], rdata [2];
  logic [31:0] mm [2][DP0];
  exp_t sq [$];
  int edges = 0, passed = 0, total = 0, dcnt = 0;

  dmem_ctrl #(.DEPTH_WORDS(DP0), .BASE_ADDR(BASE), .RD_LAT(1)) u1 (
    .clk_in(clk), .reset(reset[0]), .req(req[0]), .we(we[0]), .size(size[0]), .sign_ext(sign_ext[0]),
    .addr(addr[0]), .wdata(wdata[0]), .ready(ready[0]), .done(done[0]), .rdata(rdata[0]), .err(err[0]));
  dmem_ctrl #(.DEPTH_WORDS(DP1), .BASE_ADDR(BASE), .RD_LAT(3)) u3 (
    .clk_in(clk), .reset(reset[1]), .req(req[1]), .we(we[1]), .size(size[1]), .sign_ext(sign_ext[1]),
    .addr(addr[1]), .wdata(wdata[1]), .ready(ready[1]), .done(done[1]), .rdata(rdata[1]), .err(err[1]));

  always @(posedge clk) edges <= edges + 1;
  always @(negedge clk) if (done[1]) dcnt <= dcnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h want=%h", tag, got, exp);
    else passed++;
  endtask

  task automatic model(input int i, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, output logic [31:0] d, output logic e);
    int dp, ix, ln;
    logic [31:0] off, v;
    dp = i ? DP1 : DP0;
    off = a - BASE;
    e = a < BASE || off >= 32'(dp * 4);
    ix = int'(off >> 2);
    ln = int'(off[1:0]);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((sz == 2'd1 && off[0]) || (sz >= 2'd2 && off[1:0] != 2'd0)) e = 1;
`else
    if (sz == 2'd1) ln = ln & 2;
    else if (sz >= 2'd2) ln = 0;
`endif
    d = 0;
    if (!e) begin
      if (w) begin
        if (sz == 2'd0) mm[i][ix][8*ln +: 8] = wd[7:0];
        else if (sz == 2'd1) mm[i][ix][8*ln +: 16] = wd[15:0];
        else mm[i][ix] = wd;
      end else begin
        v = mm[i][ix] >> (8 * ln);
        if (sz == 2'd0) d = sx ? {{24{v[7]}}, v[7:0]} : {24'd0, v[7:0]};
        else if (sz == 2'd1) d = sx ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
        else d = mm[i][ix];
      end
    end
  endtask

  task automatic acc(input int i, input logic w, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] wd);
    exp_t x;
    int n = 0;
    @(negedge clk);
    while (!ready[i] && n < 20) begin @(negedge clk); n++; end
    if (!ready[i]) begin chk("ready_timeout", 32'(ready[i]), 1); return; end
    req[i] = 1; we[i] = w; size[i] = sz; sign_ext[i] = sx; addr[i] = a; wdata[i] = wd;
    x.inst = i; x.ld = !w;
    model(i, w, sz, sx, a, wd, x.d, x.e);
    @(posedge clk); #1;
    x.due = edges + (w ? 0 : (i ? 3 : 1));
    sq.push_back(x);
    req[i] = 0;
  endtask

  task automatic sw(input int i, input logic [31:0] a, input logic [31:0] d); acc(i, 1, 2'd2, 0, a, d); endtask
  task automatic ld(input int i, input logic [1:0] sz, input logic sx, input logic [31:0] a); acc(i, 0, sz, sx, a, 0); endtask

  task automatic drain();
    int n = 0;
    while (sq.size() > 0 && n < 50) begin @(negedge clk); n++; end
    chk("drain", 32'(sq.size()), 0);
  endtask

  // completions are matched in order; a head entry past its due edge without done is a miss
  always @(negedge clk) begin
    exp_t x;
    for (int i = 0; i < 2; i++)
      if (done[i]) begin
        if (sq.size() > 0 && sq[0].inst == i) begin
          x = sq.pop_front();
          chk("latency", edges, x.due);
          chk("err", 32'(err[i]), 32'(x.e));
          if (x.ld) chk("rdata", rdata[i], x.d);
        end else chk("spurious_done", 32'(done[i]), 0);
      end
    if (sq.size() > 0 && sq[0].due <= edges) begin
      chk("done_missing", 32'(done[sq[0].inst]), 1);
      void'(sq.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int a0;
    int d0;
    logic [31:0] v;
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1; req[i] = 0; we[i] = 0; size[i] = 0; sign_ext[i] = 0; addr[i] = 0; wdata[i] = 0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 32'(ready[i]), 0);
      chk("rst_done", 32'(done[i]), 0);
      chk("rst_err", 32'(err[i]), 0);
      chk("rst_rdata", rdata[i], 0);
    end
    reset[0] = 0; reset[1] = 0;
    #1;
    chk("ready_after_rst0", 32'(ready[0]), 1);
    chk("ready_after_rst1", 32'(ready[1]), 1);
    sw(0, BASE, 32'hDEADBEEF);
    ld(0, 2'd2, 0, BASE);
    sw(0, BASE, 32'h11223344);
    acc(0, 1, 2'd0, 0, BASE + 3, 32'h00000080);
    ld(0, 2'd2, 0, BASE);
    ld(0, 2'd0, 1, BASE + 3);
    ld(0, 2'd0, 0, BASE + 3);
    sw(0, BASE + 4, 32'h55667788);
    acc(0, 1, 2'd1, 0, BASE + 6, 32'h00009ABC);
    ld(0, 2'd1, 1, BASE + 6);
    ld(0, 2'd1, 0, BASE + 6);
    ld(0, 2'd2, 0, BASE + 4);
    ld(0, 2'd2, 0, BASE + 2);
    ld(0, 2'd1, 1, BASE + 5);
    acc(0, 1, 2'd1, 0, BASE + 1, 32'h0000A55A);
    acc(0, 1, 2'd3, 0, BASE + 7, 32'h01020304);
    ld(0, 2'd3, 1, BASE + 4);
    ld(0, 2'd2, 0, BASE);
    for (int w = 2; w < 8; w++) sw(0, BASE + 32'(4 * w), $urandom);
    for (int n = 0; n < 200; n++)
      acc(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 15) == 0 ? BASE - 32'($urandom_range(1, 8)) : BASE + 32'($urandom_range(0, 31)), $urandom);
    drain();
    for (int w = 0; w < DP0; w++) begin
      v = 32'(w) * 32'h9E3779B9;
      sw(0, BASE + 32'(4 * w), v);
    end
    ld(0, 2'd2, 0, 32'h1000FFFC);
    ld(0, 2'd2, 0, BASE + 32'(DP0 * 4));
    sw(0, 32'h1000FFFC, 32'hFFFFFFFF);
    sw(0, BASE + 32'(DP0 * 4), 32'hFFFFFFFF);
    acc(0, 1, 2'd0, 0, 32'h1000FFFF, 32'h000000EE);
    acc(0, 1, 2'd1, 0, BASE + 32'(DP0 * 4) + 2, 32'h0000EEEE);
    for (int w = 0; w < DP0; w++) ld(0, 2'd2, 0, BASE + 32'(4 * w));
    drain();
    sw(1, BASE, 32'hCAFEF00D);
    drain();
    @(negedge clk);
    req[1] = 1; we[1] = 0; size[1] = 2'd2; addr[1] = BASE;
    @(posedge clk); #1;
    req[1] = 0;
    chk("rd_ready_low", 32'(ready[1]), 0);
    @(posedge clk); #1;
    reset[1] = 1;
    #1;
    chk("abort_ready_in_rst", 32'(ready[1]), 0);
    chk("abort_done_in_rst", 32'(done[1]), 0);
    @(negedge clk);
    reset[1] = 0;
    #1;
    chk("abort_ready", 32'(ready[1]), 1);
    repeat (6) @(negedge clk);
    ld(1, 2'd2, 0, BASE);
    drain();
    d0 = dcnt;
    a0 = 0;
    for (int j = 0; j < 8; j++) begin
      sw(1, BASE + 32'(4 * j), 32'hA0000000 | 32'(j * 32'h01010101));
      if (j == 0) a0 = edges;
      else chk("b2b_ready", 32'(ready[1]), 1);
    end
    chk("b2b_span", edges - a0, 7);
    drain();
    chk("b2b_dones", dcnt - d0, 8);
    for (int j = 0; j < 8; j++) ld(1, 2'd2, 0, BASE + 32'(4 * j));
    ld(1, 2'd2, 0, BASE + 32'(DP1 * 4));
    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
